// File: rtl/knn_batch_ctrl_pkg.sv
// Shared definitions for the KNN batch controller: state encoding, default
// drain length and a counter-width helper.
package knn_batch_ctrl_pkg;

    localparam int unsigned DRAIN_CYC_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/knn_cnt.sv
// Exact-width address/cycle counter with synchronous clear, increment and a
// terminal-count flag against a supplied last value.
module knn_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    // Clear wins over increment so a restart always lands on zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc_c = (cnt == last);

endmodule

// File: rtl/knn_batch_ctrl.sv
// Batch sequencer for the KNN datapath: for each test point it clears the
// neighbour list, streams every data point, drains the pipeline and stores.
module knn_batch_ctrl
    import knn_batch_ctrl_pkg::*;
#(
    parameter int unsigned TW        = 8,
    parameter int unsigned DW        = 16,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] n_test,
    input  logic [DW-1:0] n_data,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] test_addr,
    output logic [DW-1:0] data_addr,
    output logic          mem_rd,
    output logic          dp_clr,
    output logic          dp_enable,
    output logic          res_we,
    output logic [TW-1:0] res_addr
);

    localparam int unsigned DCW = cnt_width(DRAIN_CYC);

    state_e        state;
    state_e        state_next;
    logic [TW-1:0] n_test_m1;
    logic [DW-1:0] n_data_m1;
    logic [DCW-1:0] drain_cnt;
    logic          test_tc_c;
    logic          data_tc_c;
    logic          drain_tc_c;
    logic          start_acc;
    logic          busy_d;
    logic          done_d;
    logic          mem_rd_d;
    logic          dp_clr_d;
    logic          res_we_d;

    // Next state and next registered outputs; abort overrides every transition.
    always_comb begin
        state_next = state;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mem_rd_d   = 1'b0;
        dp_clr_d   = 1'b0;
        res_we_d   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((n_test != '0) && (n_data != '0)) begin
                        state_next = ST_CLEAR;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_CLEAR:  state_next = ST_STREAM;
            ST_STREAM: begin
                if (data_tc_c) begin
                    if (DRAIN_CYC == 0) begin
                        state_next = ST_STORE;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_tc_c) begin
                    state_next = ST_STORE;
                end
            end
            ST_STORE: begin
                if (test_tc_c) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CLEAR;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if (abort) begin
            state_next = ST_IDLE;
        end

        busy_d   = (state_next != ST_IDLE) && (state_next != ST_DONE);
        done_d   = (state_next == ST_DONE);
        mem_rd_d = (state_next == ST_STREAM);
        dp_clr_d = (state_next == ST_CLEAR);
        res_we_d = (state_next == ST_STORE);
    end

    assign start_acc = (state == ST_IDLE) && (state_next == ST_CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            dp_clr    <= 1'b0;
            dp_enable <= 1'b0;
            res_we    <= 1'b0;
            res_addr  <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            mem_rd    <= mem_rd_d;
            dp_clr    <= dp_clr_d;
            dp_enable <= mem_rd;
            res_we    <= res_we_d;
            if (res_we_d) begin
                res_addr <= test_addr;
            end
        end
    end

    // Counts are held as last-index values so counters compare exact-width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_test_m1 <= '0;
            n_data_m1 <= '0;
        end else if (start_acc) begin
            n_test_m1 <= n_test - TW'(1);
            n_data_m1 <= n_data - DW'(1);
        end
    end

    knn_cnt #(.W(TW)) u_test_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_acc),
        .inc  ((state == ST_STORE) && (state_next == ST_CLEAR)),
        .last (n_test_m1),
        .cnt  (test_addr),
        .tc_c (test_tc_c)
    );

    // Holds at the last index during DRAIN instead of wrapping.
    knn_cnt #(.W(DW)) u_data_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_next == ST_CLEAR),
        .inc  ((state == ST_STREAM) && !data_tc_c),
        .last (n_data_m1),
        .cnt  (data_addr),
        .tc_c (data_tc_c)
    );

    knn_cnt #(.W(DCW)) u_drain_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != ST_DRAIN),
        .inc  (1'b1),
        .last (DCW'(DRAIN_CYC - 1)),
        .cnt  (drain_cnt),
        .tc_c (drain_tc_c)
    );

endmodule

// File: tb/tb_knn_batch_ctrl.sv
// Scoreboard bench for knn_batch_ctrl: stimulus queues expected res_we/done
// events with their cycle, a negedge monitor pops and compares them.
module tb_knn_batch_ctrl;

    localparam int unsigned TW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned D  = 3;

    typedef struct {
        bit is_done;
        int addr;
        int cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] n_test;
    logic [DW-1:0] n_data;
    logic          busy;
    logic          done;
    logic [TW-1:0] test_addr;
    logic [DW-1:0] data_addr;
    logic          mem_rd;
    logic          dp_clr;
    logic          dp_enable;
    logic          res_we;
    logic [TW-1:0] res_addr;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  cnt_rd, cnt_clr, cnt_en, cnt_we;
    int  done_seen = 0;
    int  done_base = 0;
    int  last_done_cyc = 0;
    int  exp_daddr = 0;
    bit  prev_rd = 1'b0;

    knn_batch_ctrl #(.TW(TW), .DW(DW), .DRAIN_CYC(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .n_test    (n_test),
        .n_data    (n_data),
        .busy      (busy),
        .done      (done),
        .test_addr (test_addr),
        .data_addr (data_addr),
        .mem_rd    (mem_rd),
        .dp_clr    (dp_clr),
        .dp_enable (dp_enable),
        .res_we    (res_we),
        .res_addr  (res_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle protocol checks plus scoreboard pops on res_we/done.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            prev_rd   = 1'b0;
            exp_daddr = 0;
        end else begin
            chk("dp_enable_delay", longint'(dp_enable), longint'(prev_rd));
            if (dp_clr) begin
                cnt_clr++;
                exp_daddr = 0;
            end
            if (dp_enable) cnt_en++;
            if (mem_rd) begin
                chk("data_addr", longint'(data_addr), longint'(exp_daddr));
                exp_daddr++;
                cnt_rd++;
            end
            if (res_we || done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: res_we=%0d done=%0d at cycle %0d, expected none",
                             res_we, done, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", longint'(done), longint'(e.is_done));
                    chk("event_cycle", longint'(cyc), longint'(e.cyc));
                    if (res_we) begin
                        chk("res_addr", longint'(res_addr), longint'(e.addr));
                        chk("res_addr_eq_test_addr", longint'(res_addr), longint'(test_addr));
                    end
                end
                if (res_we) cnt_we++;
                if (done) begin
                    done_seen++;
                    last_done_cyc = cyc;
                end
            end
            prev_rd = mem_rd;
        end
    end

    // Issue one start; state after the k-th edge is seen at cyc == t0 + k.
    task automatic start_batch(input int nt, input int nd, input bit push);
        int p;
        ev_t e;
        p = 1 + nd + int'(D) + 1;
        @(negedge clk);
        cnt_rd = 0; cnt_clr = 0; cnt_en = 0; cnt_we = 0;
        done_base = done_seen;
        n_test = TW'(nt);
        n_data = DW'(nd);
        start  = 1'b1;
        t0     = cyc;
        if (push) begin
            if (nt != 0 && nd != 0) begin
                for (int i = 0; i < nt; i++) begin
                    e = '{1'b0, i, t0 + (i + 1) * p};
                    sb.push_back(e);
                end
                e = '{1'b1, 0, t0 + nt * p + 1};
                sb.push_back(e);
            end else begin
                e = '{1'b1, 0, t0 + 1};
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int c = 0; c < bound && done_seen == done_base; c++) @(negedge clk);
        chk("done_seen", longint'(done_seen - done_base), 1);
        @(negedge clk);
    endtask

    function automatic longint outs_vec();
        return longint'({busy, done, test_addr, data_addr, mem_rd, dp_clr,
                         dp_enable, res_we, res_addr});
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_test = '0; n_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs_vec(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", longint'(busy), 0);

        // Two test points of four data points: done 19 edges after start.
        start_batch(2, 4, 1);
        wait_done(100);
        chk("b24_done_latency", longint'(last_done_cyc - t0), 19);
        chk("b24_mem_rd", cnt_rd, 8);
        chk("b24_dp_clr", cnt_clr, 2);
        chk("b24_dp_enable", cnt_en, 8);
        chk("b24_res_we", cnt_we, 2);

        // Zero test points: straight to DONE.
        start_batch(0, 5, 1);
        wait_done(20);
        chk("nt0_done_latency", longint'(last_done_cyc - t0), 1);
        chk("nt0_mem_rd", cnt_rd, 0);
        chk("nt0_res_we", cnt_we, 0);

        // Zero data points: same short path.
        start_batch(3, 0, 1);
        wait_done(20);
        chk("nd0_done_latency", longint'(last_done_cyc - t0), 1);
        chk("nd0_mem_rd", cnt_rd, 0);
        chk("nd0_dp_clr", cnt_clr, 0);

        // Single data point, single test point.
        start_batch(1, 1, 1);
        wait_done(40);
        chk("b11_done_latency", longint'(last_done_cyc - t0), 7);
        chk("b11_mem_rd", cnt_rd, 1);
        chk("b11_dp_enable", cnt_en, 1);

        // Start while busy with other counts must be ignored.
        start_batch(1, 5, 1);
        repeat (3) @(negedge clk);
        n_test = TW'(3);
        n_data = DW'(2);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(60);
        chk("ignored_start_mem_rd", cnt_rd, 5);
        chk("ignored_start_dp_clr", cnt_clr, 1);
        chk("ignored_start_res_we", cnt_we, 1);

        // Full-range test count must not wrap early.
        start_batch(255, 1, 1);
        wait_done(2000);
        chk("nt255_res_we", cnt_we, 255);
        chk("nt255_done_latency", longint'(last_done_cyc - t0), 1531);

        // Data count above eight bits.
        start_batch(1, 300, 1);
        wait_done(400);
        chk("nd300_mem_rd", cnt_rd, 300);

        // Abort in the first DRAIN cycle of test point 0.
        start_batch(2, 4, 0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_res_we", longint'(res_we), 0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", longint'(done_seen - done_base), 0);
        chk("abort_no_res_we", cnt_we, 0);
        chk("abort_mem_rd", cnt_rd, 4);

        // Reset in the middle of STREAM, then a clean batch.
        start_batch(1, 8, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", outs_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_reset_idle", longint'(busy), 0);
        start_batch(2, 3, 1);
        wait_done(60);
        chk("post_reset_mem_rd", cnt_rd, 6);
        chk("post_reset_res_we", cnt_we, 2);

        chk("scoreboard_empty", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
